// File: rtl/solver_ctrl.sv
// Sequencer for an iterative linear solver: load, sweep, drain, unload.
// Define SOLVER_EARLY_STOP_EN to end sweeping once a full sweep converges.
module solver_ctrl #(
  parameter int N        = 16,
  parameter int MAX_ITER = 20,
  parameter int PIPE_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 conv,
  output logic                 ready,
  output logic                 load_en,
  output logic                 rot_en,
  output logic [$clog2(N)-1:0] row_idx,
  output logic [7:0]           iter_cnt,
  output logic                 out_valid,
  output logic                 done
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic          r_ready;
  logic          r_rot;
  logic [RW-1:0] r_row;
  logic [7:0]    r_iter;
  logic          r_oval;
  logic          r_done;
  logic [CW-1:0] r_lcnt;
  logic [DW-1:0] r_dcnt;

  logic w_last_row;
  logic w_last_sweep;
  logic w_stop;
  logic w_load;

  assign w_last_row   = (r_row == RW'(N - 1));
  assign w_last_sweep = (r_iter == 8'(MAX_ITER - 1));
  assign w_load       = (r_state == S_LOAD) & in_valid;

`ifdef SOLVER_EARLY_STOP_EN
  logic r_allconv;
  logic w_conv_all;

  // Running AND of conv across the current sweep, restarted at row 0.
  assign w_conv_all = (r_row == '0) ? conv : (r_allconv & conv);
  assign w_stop     = w_last_sweep | w_conv_all;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_allconv <= 1'b0;
    end else if (r_state == S_ITER) begin
      r_allconv <= w_conv_all;
    end
  end
`else
  logic w_unused_conv;

  assign w_unused_conv = conv;
  assign w_stop        = w_last_sweep;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_rot   <= 1'b0;
      r_row   <= '0;
      r_iter  <= '0;
      r_oval  <= 1'b0;
      r_done  <= 1'b0;
      r_lcnt  <= '0;
      r_dcnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_ready <= 1'b0;
            r_iter  <= '0;
            r_row   <= '0;
            r_lcnt  <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (r_lcnt == CW'(N - 1)) begin
              r_state <= S_ITER;
              r_rot   <= 1'b1;
              r_row   <= '0;
              r_lcnt  <= '0;
            end else begin
              r_lcnt <= r_lcnt + 1'b1;
            end
          end
        end
        S_ITER: begin
          if (w_last_row) begin
            r_row <= '0;
            if (r_iter < 8'(MAX_ITER)) begin
              r_iter <= r_iter + 8'd1;
            end
            if (w_stop) begin
              r_state <= S_DRAIN;
              r_rot   <= 1'b0;
              r_dcnt  <= '0;
            end
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DW'(PIPE_LAT - 1)) begin
            r_state <= S_OUT;
            r_rot   <= 1'b1;
            r_oval  <= 1'b1;
            r_row   <= '0;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_OUT: begin
          if (w_last_row) begin
            r_state <= S_DONE;
            r_rot   <= 1'b0;
            r_oval  <= 1'b0;
            r_done  <= 1'b1;
            r_row   <= '0;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_rot   <= 1'b0;
          r_oval  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign load_en   = w_load;
  assign rot_en    = r_rot;
  assign row_idx   = r_row;
  assign iter_cnt  = r_iter;
  assign out_valid = r_oval;
  assign done      = r_done;

endmodule

// File: tb/tb_solver_ctrl.sv
// Scoreboard bench for solver_ctrl: phase lengths, row order, reset, restart.
`timescale 1ns/1ps
module tb_solver_ctrl;

  localparam int N        = 16;
  localparam int MAX_ITER = 20;
  localparam int PIPE_LAT = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       conv;
  logic       ready;
  logic       load_en;
  logic       rot_en;
  logic [3:0] row_idx;
  logic [7:0] iter_cnt;
  logic       out_valid;
  logic       done;

  int  n_chk;
  int  n_fail;
  bit  conv_mode;
  int  exp_q[$];
  int  row_q[$];

  solver_ctrl #(
    .N(N),
    .MAX_ITER(MAX_ITER),
    .PIPE_LAT(PIPE_LAT)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .conv(conv),
    .ready(ready),
    .load_en(load_en),
    .rot_en(rot_en),
    .row_idx(row_idx),
    .iter_cnt(iter_cnt),
    .out_valid(out_valid),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Convergence is reported from the third sweep onward.
  assign conv = conv_mode && (iter_cnt >= 8'd2);

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_solve(input logic [3:0] pat, input bit hold,
                           input bit cmode, input int exp_iter);
    int nload, niter, ndrain, nout, ndone, fin_iter;
    int cyc, k, last_load, first_rot, row_err, rdy_err, iter0;
    bit seen_done, fin;
    nload = 0; niter = 0; ndrain = 0; nout = 0; ndone = 0;
    fin_iter = -1; cyc = 0; k = 0; last_load = -10; first_rot = -1;
    row_err = 0; rdy_err = 0; iter0 = -1; seen_done = 0; fin = 0;
    exp_q.push_back(N);
    exp_q.push_back(exp_iter * N);
    exp_q.push_back(PIPE_LAT);
    exp_q.push_back(N);
    exp_q.push_back(1);
    exp_q.push_back(exp_iter);
    for (int r = 0; r < N; r++) row_q.push_back(r);
    conv_mode = cmode;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    if (!hold) start = 1'b0;
    while (!fin && cyc < 2000) begin
      if (nload < N) begin
        in_valid = pat[k % 4];
        k++;
      end else begin
        in_valid = 1'b0;
      end
      if (seen_done) start = 1'b0;
      #1;
      if (iter0 < 0) iter0 = iter_cnt;
      if (ready) begin
        if (seen_done) fin = 1;
        else rdy_err++;
      end
      if (!fin) begin
        if (load_en) begin
          nload++;
          last_load = cyc;
        end
        if (rot_en && !out_valid) begin
          if (first_rot < 0) first_rot = cyc;
          if (row_idx != 4'((niter) % N)) row_err++;
          niter++;
        end
        if (niter > 0 && nout == 0 && !rot_en) ndrain++;
        if (out_valid) begin
          nout++;
          if (row_q.size() > 0) chk("out_row", row_idx, row_q.pop_front());
          else chk("out_row_extra", nout, N);
        end
        if (done) begin
          ndone++;
          fin_iter = iter_cnt;
          seen_done = 1;
        end
      end
      cyc++;
      if (!fin) @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    conv_mode = 1'b0;
    chk("timeout", fin, 1);
    chk("iter_clr", iter0, 0);
    chk("ready_low", rdy_err, 0);
    chk("iter_entry", first_rot - last_load, 1);
    chk("iter_row", row_err, 0);
    chk("load_cnt", nload, exp_q.pop_front());
    chk("iter_cyc", niter, exp_q.pop_front());
    chk("drain_cyc", ndrain, exp_q.pop_front());
    chk("out_cyc", nout, exp_q.pop_front());
    chk("done_cnt", ndone, exp_q.pop_front());
    chk("iter_fin", fin_iter, exp_q.pop_front());
    chk("iter_hold", iter_cnt, fin_iter);
    while (row_q.size() > 0) void'(row_q.pop_front());
  endtask

  int exp_conv_iter;
  int wait_cyc;
  int done_seen;

  initial begin
    n_chk = 0;
    n_fail = 0;
    conv_mode = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    rst = 1'b0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_load", load_en, 0);
    chk("rst_rot", rot_en, 0);
    chk("rst_oval", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_row", row_idx, 0);
    chk("rst_iter", iter_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_solve(4'b1111, 1'b0, 1'b0, MAX_ITER);
    run_solve(4'b1001, 1'b0, 1'b0, MAX_ITER);
`ifdef SOLVER_EARLY_STOP_EN
    exp_conv_iter = 3;
`else
    exp_conv_iter = MAX_ITER;
`endif
    run_solve(4'b1111, 1'b0, 1'b1, exp_conv_iter);

    // Abort mid-sweep with an asynchronous reset.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    wait_cyc = 0;
    while (!(rot_en && row_idx == 4'd7 && iter_cnt == 8'd1) && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    in_valid = 1'b0;
    chk("mid_reach", wait_cyc < 200, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_rot", rot_en, 0);
    chk("arst_row", row_idx, 0);
    chk("arst_iter", iter_cnt, 0);
    chk("arst_oval", out_valid, 0);
    chk("arst_load", load_en, 0);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("arst_nodone", done_seen, 0);
    chk("arst_idle", ready, 1);
    run_solve(4'b1111, 1'b0, 1'b0, MAX_ITER);

    run_solve(4'b1111, 1'b1, 1'b0, MAX_ITER);
    @(negedge clk);
    #1;
    chk("hold_idle", ready, 1);
    chk("hold_noload", load_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
